// File: rtl/reaction_timer_nd.sv
// Reaction timer. A start request arms a pseudo-random wait, then the LED lights and a
// BCD count runs until the push button is hit. Also tracks false starts, overflow and best time.
module reaction_timer_nd #(
    parameter int NUM_DIGITS = 2,
    parameter int TICK_DIV   = 500000,
    parameter int MIN_DELAY  = 100,
    parameter int RAND_BITS  = 8
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      rst,
    input  logic                      w,
    input  logic                      Pushn,
    output logic                      LEDn,
    output logic [7*NUM_DIGITS-1:0]   Digits,
    output logic [4*NUM_DIGITS-1:0]   best_bcd,
    output logic                      busy,
    output logic                      false_start,
    output logic                      overflow
);

    localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DLY_W = $clog2(MIN_DELAY + (2 ** RAND_BITS)) + 1;
    localparam int CNT_W = 4 * NUM_DIGITS;

    localparam logic [6:0]       SEG_DASH = 7'h3F;
    localparam logic [15:0]      LFSR_SEED = 16'hACE1;
    localparam logic [CNT_W-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
    endfunction

    state_t             state_q, state_d;
    logic               w_meta_q, w_meta_d, w_sync_q, w_sync_d, w_prev_q, w_prev_d;
    logic               p_meta_q, p_meta_d, p_sync_q, p_sync_d, p_prev_q, p_prev_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DLY_W-1:0]   delay_q, delay_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   best_q, best_d;
    logic               fs_q, fs_d;
    logic               ovf_q, ovf_d;
    logic               led_n_q, led_n_d;
    logic               busy_q, busy_d;

    logic               start_s;
    logic               press_s;
    logic               tick_s;
    logic [CNT_W-1:0]   count_inc_s;
    logic               inc_carry_s;
    logic [DLY_W-1:0]   arm_delay_s;

    // Synchroniser and edge-detect next values; Pushn idles high so its chain resets to 1
    always_comb begin
        w_meta_d = w;
        w_sync_d = w_meta_q;
        w_prev_d = w_sync_q;
        p_meta_d = Pushn;
        p_sync_d = p_meta_q;
        p_prev_d = p_sync_q;
        lfsr_d   = lfsr_step(lfsr_q);
    end

    assign start_s     = w_sync_q & ~w_prev_q;
    assign press_s     = ~p_sync_q & p_prev_q;
    assign tick_s      = (div_q == DIV_W'(TICK_DIV - 1));
    assign arm_delay_s = DLY_W'(MIN_DELAY) + DLY_W'(lfsr_q[RAND_BITS-1:0]);

    // BCD increment with ripple carry; a carry out of the top digit means the count is all 9s
    always_comb begin
        count_inc_s = count_q;
        inc_carry_s = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (inc_carry_s) begin
                if (count_q[4*k +: 4] == 4'd9) begin
                    count_inc_s[4*k +: 4] = 4'd0;
                end else begin
                    count_inc_s[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
                    inc_carry_s           = 1'b0;
                end
            end else begin
                count_inc_s[4*k +: 4] = count_q[4*k +: 4];
            end
        end
    end

    // FSM next state plus datapath next values; sync reset overrides every event
    always_comb begin
        state_d = state_q;
        div_d   = tick_s ? '0 : (div_q + DIV_W'(1));
        delay_d = delay_q;
        count_d = count_q;
        best_d  = best_q;
        fs_d    = fs_q;
        ovf_d   = ovf_q;

        if (rst) begin
            state_d = S_IDLE;
            div_d   = '0;
            delay_d = '0;
            count_d = '0;
            fs_d    = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_FAULT: begin
                    if (start_s) begin
                        state_d = S_WAIT;
                        div_d   = '0;
                        delay_d = arm_delay_s;
                        count_d = '0;
                        fs_d    = 1'b0;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = state_q;
                    end
                end
                S_WAIT: begin
                    if (press_s) begin
                        state_d = S_FAULT;
                        fs_d    = 1'b1;
                    end else if (tick_s) begin
                        if (delay_q <= DLY_W'(1)) begin
                            state_d = S_RUN;
                            delay_d = '0;
                            div_d   = '0;
                        end else begin
                            delay_d = delay_q - DLY_W'(1);
                        end
                    end else begin
                        delay_d = delay_q;
                    end
                end
                S_RUN: begin
                    // A press in the same cycle as a tick freezes the count without that tick
                    if (press_s) begin
                        state_d = S_DONE;
                    end else if (tick_s) begin
                        if (inc_carry_s) begin
                            ovf_d = 1'b1;
                        end else begin
                            count_d = count_inc_s;
                        end
                    end else begin
                        count_d = count_q;
                    end
                end
                S_DONE: begin
                    // Packed BCD keeps numeric order, so a plain unsigned compare is valid
                    if (!ovf_q && (count_q < best_q)) begin
                        best_d = count_q;
                    end else begin
                        best_d = best_q;
                    end
                    if (start_s) begin
                        state_d = S_WAIT;
                        div_d   = '0;
                        delay_d = arm_delay_s;
                        count_d = '0;
                        fs_d    = 1'b0;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        led_n_d = (state_d != S_RUN);
        busy_d  = (state_d == S_WAIT) || (state_d == S_RUN);
    end

    // State and datapath registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            w_meta_q <= 1'b0;
            w_sync_q <= 1'b0;
            w_prev_q <= 1'b0;
            p_meta_q <= 1'b1;
            p_sync_q <= 1'b1;
            p_prev_q <= 1'b1;
            lfsr_q   <= LFSR_SEED;
            div_q    <= '0;
            delay_q  <= '0;
            count_q  <= '0;
            best_q   <= ALL_NINES;
            fs_q     <= 1'b0;
            ovf_q    <= 1'b0;
            led_n_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            w_meta_q <= w_meta_d;
            w_sync_q <= w_sync_d;
            w_prev_q <= w_prev_d;
            p_meta_q <= p_meta_d;
            p_sync_q <= p_sync_d;
            p_prev_q <= p_prev_d;
            lfsr_q   <= lfsr_d;
            div_q    <= div_d;
            delay_q  <= delay_d;
            count_q  <= count_d;
            best_q   <= best_d;
            fs_q     <= fs_d;
            ovf_q    <= ovf_d;
            led_n_q  <= led_n_d;
            busy_q   <= busy_d;
        end
    end

    // Segment drive: dashes on a false start, otherwise the live count
    always_comb begin
        Digits = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (state_q == S_FAULT) begin
                Digits[7*k +: 7] = SEG_DASH;
            end else begin
                Digits[7*k +: 7] = seg_encode(count_q[4*k +: 4]);
            end
        end
    end

    assign LEDn        = led_n_q;
    assign best_bcd    = best_q;
    assign busy        = busy_q;
    assign false_start = fs_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_reaction_timer_nd.sv
// Bench for reaction_timer_nd: expected timing and counts are derived arithmetically
// from the reaction-timer rules (tick period, synchroniser latency, saturation, best time).
module tb_reaction_timer_nd;

    localparam int ND = 2;
    localparam int TD = 4;
    localparam int MD = 3;
    localparam int RB = 2;
    localparam logic [6:0] DASH = 7'h3F;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        rst;
    logic        w;
    logic        Pushn;
    logic        LEDn;
    logic [13:0] Digits;
    logic [7:0]  best_bcd;
    logic        busy;
    logic        false_start;
    logic        overflow;

    int total = 0;
    int bad   = 0;
    int model_best = 99;
    logic [15:0] m_lfsr;

    typedef struct {
        int         k;
        logic [7:0] exp_best;
    } vec_t;

    always #5 Clock = ~Clock;

    reaction_timer_nd #(
        .NUM_DIGITS(ND), .TICK_DIV(TD), .MIN_DELAY(MD), .RAND_BITS(RB)
    ) dut (
        .Clock(Clock), .Reset(Reset), .rst(rst), .w(w), .Pushn(Pushn),
        .LEDn(LEDn), .Digits(Digits), .best_bcd(best_bcd), .busy(busy),
        .false_start(false_start), .overflow(overflow)
    );

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, one step per clock
    always @(posedge Clock or posedge Reset) begin
        if (Reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [13:0] disp(input int v);
        return {seg(v / 10), seg(v % 10)};
    endfunction

    function automatic logic [7:0] bcd(input int v);
        logic [7:0] r;
        r = 8'((v / 10) * 16 + (v % 10));
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge Clock);
    endtask

    // Raise w; the FSM acts on the third edge using the LFSR value present just before it
    task automatic arm(output int d);
        w = 1'b1;
        cyc(2);
        d = MD + int'(m_lfsr[RB-1:0]);
        cyc(1);
        w = 1'b0;
        chk("arm_busy", busy, 1);
        chk("arm_led", LEDn, 1);
        chk("arm_fs_clr", false_start, 0);
        chk("arm_ovf_clr", overflow, 0);
    endtask

    task automatic to_run(input int d);
        cyc(d * TD - 1);
        chk("led_before_run", LEDn, 1);
        cyc(1);
        chk("led_on", LEDn, 0);
        chk("run_busy", busy, 1);
        chk("run_zero", Digits, disp(0));
    endtask

    // Press m cycles after the current point; it takes effect 3 edges later
    task automatic press_run(input int m, input int exp_cnt, input logic exp_ovf,
                             input logic [7:0] exp_best);
        cyc(m);
        Pushn = 1'b0;
        cyc(3);
        chk("done_digits", Digits, disp(exp_cnt));
        chk("done_led", LEDn, 1);
        chk("done_busy", busy, 0);
        chk("done_ovf", overflow, exp_ovf);
        cyc(1);
        chk("done_best", best_bcd, exp_best);
        Pushn = 1'b1;
        cyc(3);
    endtask

    task automatic false_round(input int m);
        cyc(m);
        Pushn = 1'b0;
        cyc(3);
        chk("fs_flag", false_start, 1);
        chk("fs_dash", Digits, {DASH, DASH});
        chk("fs_led", LEDn, 1);
        chk("fs_busy", busy, 0);
        chk("fs_best", best_bcd, bcd(model_best));
        Pushn = 1'b1;
        cyc(3);
    endtask

    initial begin
        vec_t vecs[3];
        int d;
        int m;
        int cnt;
        int nb;

        vecs[0] = '{k: 12, exp_best: 8'h07};
        vecs[1] = '{k: 5,  exp_best: 8'h05};
        vecs[2] = '{k: 20, exp_best: 8'h05};

        Reset = 1'b1; rst = 1'b0; w = 1'b0; Pushn = 1'b1;
        #2;
        chk("rst_led", LEDn, 1);
        chk("rst_best", best_bcd, 8'h99);
        cyc(3);
        Reset = 1'b0;
        cyc(50);
        chk("idle_led", LEDn, 1);
        chk("idle_digits", Digits, disp(0));
        chk("idle_best", best_bcd, 8'h99);
        chk("idle_busy", busy, 0);
        chk("idle_fs", false_start, 0);
        chk("idle_ovf", overflow, 0);

        // First round: watch the count step every TD cycles, press at 07
        arm(d);
        to_run(d);
        cyc(TD - 1);
        chk("step_hold0", Digits, disp(0));
        cyc(1);
        chk("step_01", Digits, disp(1));
        cyc(TD);
        chk("step_02", Digits, disp(2));
        press_run(7 * TD - 2 - 2 * TD, 7, 1'b0, 8'h07);
        model_best = 7;

        for (int i = 0; i < 3; i++) begin
            arm(d);
            to_run(d);
            press_run(vecs[i].k * TD - 2, vecs[i].k, 1'b0, vecs[i].exp_best);
            if (vecs[i].k < model_best) model_best = vecs[i].k;
        end

        // False start early in WAIT, then on the exact cycle the delay expires
        arm(d);
        false_round(2);
        arm(d);
        false_round(d * TD - 3);

        // Overflow; a w pulse while running must be ignored
        arm(d);
        to_run(d);
        w = 1'b1;
        cyc(5);
        w = 1'b0;
        cyc(438 - 5);
        chk("ovf_set", overflow, 1);
        chk("ovf_hold99", Digits, disp(99));
        press_run(0, 99, 1'b1, bcd(model_best));

        // Synchronous rst mid-RUN at count 04
        arm(d);
        to_run(d);
        cyc(4 * TD);
        chk("pre_rst_04", Digits, disp(4));
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("srst_digits", Digits, disp(0));
        chk("srst_led", LEDn, 1);
        chk("srst_busy", busy, 0);
        chk("srst_best", best_bcd, bcd(model_best));
        cyc(5);
        chk("srst_idle", busy, 0);

        // Randomised rounds against the arithmetic model
        for (int i = 0; i < 10; i++) begin
            arm(d);
            if ($urandom_range(0, 3) == 0) begin
                false_round(int'($urandom_range(0, d * TD - 3)));
            end else begin
                to_run(d);
                m = int'($urandom_range(4, 150));
                cnt = (m + 2) / TD;
                nb = (cnt < model_best) ? cnt : model_best;
                press_run(m, cnt, 1'b0, bcd(nb));
                model_best = nb;
            end
        end

        // Asynchronous Reset mid-RUN: outputs return before the next clock edge
        arm(d);
        to_run(d);
        cyc(9);
        Reset = 1'b1;
        #1;
        chk("areset_led", LEDn, 1);
        chk("areset_digits", Digits, disp(0));
        chk("areset_best", best_bcd, 8'h99);
        chk("areset_busy", busy, 0);
        chk("areset_fs", false_start, 0);
        chk("areset_ovf", overflow, 0);
        cyc(2);
        Reset = 1'b0;
        model_best = 99;
        cyc(4);
        arm(d);
        to_run(d);
        press_run(3 * TD - 2, 3, 1'b0, 8'h03);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
